// File: rtl/reg32_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : reg32_serial_tx                                        |
// | Brief   : Latches a 32-bit word and streams it one bit at a time  |
// |           over a valid/ready serial port, MSB or LSB first.      |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module reg32_serial_tx #(
  parameter int MSB_FIRST = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        En,
  input  logic        Load_Valid,
  input  logic [31:0] Data_In,
  output logic        Load_Ready,
  output logic        Ser_Out,
  output logic        Ser_Valid,
  input  logic        Ser_Ready,
  output logic [5:0]  Bit_Count,
  output logic        Done
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_word;        // word latched at accept, held for the whole frame
  logic [5:0]  r_bit_count;
  logic        r_ser_out;
  logic        r_ser_valid;
  logic        r_done;

  logic        w_accept;
  logic        w_xfer;
  logic        w_last;
  logic        w_first_bit;
  logic [4:0]  w_next_idx;
  logic        w_next_bit;

  // Bit ordering: pick which end of the word leads and how the index walks.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_first_bit = Data_In[31];
    assign w_next_idx  = 5'd30 - r_bit_count[4:0];
  end else begin : g_lsb_first
    assign w_first_bit = Data_In[0];
    assign w_next_idx  = r_bit_count[4:0] + 5'd1;
  end

  assign w_next_bit = r_word[w_next_idx];
  assign w_accept   = Load_Valid && Load_Ready;
  assign w_xfer     = r_ser_valid && Ser_Ready && En;
  assign w_last     = w_xfer && (r_bit_count == 6'd31);

  // State register, cleared asynchronously.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next_state = c_SHIFT;
      c_SHIFT: if (w_last)   w_next_state = c_DONE;
      c_DONE:  if (En)       w_next_state = c_IDLE;
      default:               w_next_state = c_IDLE;
    endcase
  end

  // Datapath registers: word latch, bit counter, serial bit, valid and done flags.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_word      <= 32'd0;
      r_bit_count <= 6'd0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
    end else if (En) begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_word      <= Data_In;
            r_bit_count <= 6'd0;
            r_ser_out   <= w_first_bit;
            r_ser_valid <= 1'b1;
          end
        end
        c_SHIFT: begin
          if (w_last) begin
            r_bit_count <= 6'd32;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_xfer) begin
            r_bit_count <= r_bit_count + 6'd1;
            r_ser_out   <= w_next_bit;
          end
        end
        c_DONE: begin
          r_done      <= 1'b0;
          r_bit_count <= 6'd0;
        end
        default: begin
          r_bit_count <= 6'd0;
          r_ser_out   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // Outputs: disabling masks valid (and the bit with it) without losing held state.
  always_comb begin
    Load_Ready = (r_state == c_IDLE) && En;
    Ser_Valid  = r_ser_valid && En;
    Ser_Out    = r_ser_out && r_ser_valid && En;
    Bit_Count  = r_bit_count;
    Done       = r_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg32_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_reg32_serial_tx                                     |
// | Brief   : Directed, table-driven bench for reg32_serial_tx; runs |
// |           an MSB-first and an LSB-first instance in lockstep.    |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_reg32_serial_tx;

  logic        Clock;
  logic        Reset;
  logic        En;
  logic        Load_Valid;
  logic [31:0] Data_In;
  logic        Ser_Ready;

  logic        lr_m, so_m, sv_m, dn_m;
  logic [5:0]  bc_m;
  logic        lr_l, so_l, sv_l, dn_l;
  logic [5:0]  bc_l;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_msb;   // transmission order, first bit at [31]
    logic [31:0] exp_lsb;   // transmission order, first bit at [31]
    int          stall_at;
    int          stall_len;
    int          en_at;
    int          en_len;
    bit          busy;
  } vec_t;

  vec_t vecs[5];
  vec_t rst_vec;

  reg32_serial_tx #(.MSB_FIRST(1)) u_dut_msb (
    .Clock(Clock), .Reset(Reset), .En(En), .Load_Valid(Load_Valid),
    .Data_In(Data_In), .Load_Ready(lr_m), .Ser_Out(so_m), .Ser_Valid(sv_m),
    .Ser_Ready(Ser_Ready), .Bit_Count(bc_m), .Done(dn_m)
  );

  reg32_serial_tx #(.MSB_FIRST(0)) u_dut_lsb (
    .Clock(Clock), .Reset(Reset), .En(En), .Load_Valid(Load_Valid),
    .Data_In(Data_In), .Load_Ready(lr_l), .Ser_Out(so_l), .Ser_Valid(sv_l),
    .Ser_Ready(Ser_Ready), .Bit_Count(bc_l), .Done(dn_l)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    int k = 0;
    while (lr_m !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check("load_ready_wait", 32'(lr_m), 1);
    Load_Valid = 1'b1;
    Data_In    = d;
    step();
    Load_Valid = 1'b0;
    Data_In    = ~d;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int cyc = 0;
    send_word(v.data);
    if (v.busy) begin
      Load_Valid = 1'b1;
      Data_In    = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s_bc%0d", tag, i), 32'(bc_m), i);
      check($sformatf("%s_sv%0d", tag, i), 32'(sv_m), 1);
      check($sformatf("%s_msb_bit%0d", tag, i), 32'(so_m), 32'(v.exp_msb[31-i]));
      check($sformatf("%s_lsb_bit%0d", tag, i), 32'(so_l), 32'(v.exp_lsb[31-i]));
      if (v.busy) check($sformatf("%s_busy_lr%0d", tag, i), 32'(lr_m), 0);
      if (i == v.stall_at) begin
        Ser_Ready = 1'b0;
        for (int k = 0; k < v.stall_len; k++) begin
          step();
          cyc++;
          check($sformatf("%s_stall_bc%0d", tag, k), 32'(bc_m), i);
          check($sformatf("%s_stall_bit%0d", tag, k), 32'(so_m), 32'(v.exp_msb[31-i]));
          check($sformatf("%s_stall_sv%0d", tag, k), 32'(sv_m), 1);
        end
        Ser_Ready = 1'b1;
      end
      if (i == v.en_at) begin
        En = 1'b0;
        #1;
        check($sformatf("%s_enoff_sv", tag), 32'(sv_m), 0);
        for (int k = 0; k < v.en_len; k++) begin
          step();
          cyc++;
          check($sformatf("%s_enoff_sv%0d", tag, k), 32'(sv_m), 0);
          check($sformatf("%s_enoff_bc%0d", tag, k), 32'(bc_m), i);
        end
        En = 1'b1;
        #1;
        check($sformatf("%s_enon_sv", tag), 32'(sv_m), 1);
        check($sformatf("%s_enon_bit", tag), 32'(so_m), 32'(v.exp_msb[31-i]));
      end
      step();
      cyc++;
    end
    check($sformatf("%s_done_m", tag), 32'(dn_m), 1);
    check($sformatf("%s_done_l", tag), 32'(dn_l), 1);
    check($sformatf("%s_done_bc", tag), 32'(bc_m), 32);
    check($sformatf("%s_done_sv", tag), 32'(sv_m), 0);
    check($sformatf("%s_done_so", tag), 32'(so_m), 0);
    check($sformatf("%s_done_cycle", tag), cyc, 32 + v.stall_len + v.en_len);
    Load_Valid = 1'b0;
    step();
    check($sformatf("%s_post_done", tag), 32'(dn_m), 0);
    check($sformatf("%s_post_lr", tag), 32'(lr_m), 1);
    check($sformatf("%s_post_bc", tag), 32'(bc_m), 0);
  endtask

  initial begin
    vecs[0] = '{32'hA500_0001, 32'hA500_0001, 32'h8000_00A5, -1, 0, -1, 0, 1'b0};
    vecs[1] = '{32'h0000_0003, 32'h0000_0003, 32'hC000_0000, -1, 0, -1, 0, 1'b0};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_0000,  5, 3, -1, 0, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, -1, 0, -1, 0, 1'b1};
    vecs[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hF77D_B57B, -1, 0, 10, 4, 1'b0};
    rst_vec = '{32'h1234_5678, 32'h1234_5678, 32'h1E6A_2C48, -1, 0, -1, 0, 1'b0};

    Reset      = 1'b0;
    En         = 1'b1;
    Load_Valid = 1'b0;
    Data_In    = 32'd0;
    Ser_Ready  = 1'b1;
    step();
    step();
    check("rst_lr", 32'(lr_m), 1);
    check("rst_sv", 32'(sv_m), 0);
    check("rst_so", 32'(so_m), 0);
    check("rst_bc", 32'(bc_m), 0);
    check("rst_done", 32'(dn_m), 0);
    En = 1'b0;
    #1;
    check("rst_lr_en0", 32'(lr_m), 0);
    En = 1'b1;
    Reset = 1'b1;
    step();

    for (int v = 0; v < 5; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

    // Reset mid-frame at Bit_Count=17: abort with no Done, then a clean frame.
    send_word(32'hCAFE_F00D);
    for (int k = 0; k < 17; k++) step();
    check("abort_bc17", 32'(bc_m), 17);
    Reset = 1'b0;
    #2;
    check("abort_sv", 32'(sv_m), 0);
    check("abort_so", 32'(so_m), 0);
    check("abort_bc", 32'(bc_m), 0);
    check("abort_done", 32'(dn_m), 0);
    check("abort_lr", 32'(lr_m), 1);
    step();
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("abort_nodone%0d", k), 32'(dn_m), 0);
      check($sformatf("abort_lr%0d", k), 32'(lr_m), 1);
    end
    run_frame(rst_vec, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
